// File: rtl/step_counter_bcd_if.sv
// step_counter_bcd_if: button/control inputs and count/BCD outputs of the step counter
interface step_counter_bcd_if #(
  parameter int WIDTH = 8,
  parameter int DIGITS = 3
);
  logic buttonM;
  logic selec;
  logic dir;
  logic [WIDTH-1:0] count;
  logic [4*DIGITS-1:0] bcd;
  logic bcd_valid;
  logic count_reached;
  modport master (output buttonM, selec, dir, input count, bcd, bcd_valid, count_reached);
  modport slave (input buttonM, selec, dir, output count, bcd, bcd_valid, count_reached);
endinterface

// File: rtl/step_counter_bcd.sv
// step_counter_bcd: synchronised push-button step counter with wrap pulse and sequential double-dabble BCD output
// STEP_COUNTER_DEBOUNCE_EN: when defined, a DEBOUNCE_CYCLES level filter sits between synchroniser and edge detector
module step_counter_bcd #(
  parameter int WIDTH = 8,
  parameter int STEP = 4,
  parameter int LIMIT = 150,
  parameter int DIGITS = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic clk,
  input logic reset,
  step_counter_bcd_if.slave bus
);
  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] STP = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] TOP = WIDTH'((LIMIT / STEP) * STEP);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CONVERT = 1'b1;
  logic [1:0] sync;
  logic db, db_q, step, hit, reached;
  logic [WIDTH-1:0] cnt, nxt;
  logic [0:0] state;
  logic [CW-1:0] bits;
  logic [BW+WIDTH-1:0] work, adj;
  logic [BW-1:0] bcd;
  always_ff @(posedge clk) sync <= reset ? 2'b00 : {sync[0], bus.buttonM};
`ifdef STEP_COUNTER_DEBOUNCE_EN
  localparam int RW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [RW-1:0] run;
  always_ff @(posedge clk)
    if (reset) begin
      db <= 1'b0;
      run <= '0;
    end else if (sync[1] == db) run <= '0;
    else if (run == RW'(DEBOUNCE_CYCLES - 1)) begin
      db <= sync[1];
      run <= '0;
    end else run <= run + 1'b1;
`else
  assign db = sync[1];
`endif
  always_ff @(posedge clk) db_q <= reset ? 1'b0 : db;
  assign step = db & ~db_q;
  always_comb begin
    nxt = cnt;
    hit = 1'b0;
    if (!bus.selec) nxt = '0;
    else if (step && !bus.dir) begin
      nxt = cnt >= LIM ? '0 : cnt + STP;
      hit = cnt >= LIM;
    end else if (step) begin
      nxt = cnt == '0 ? TOP : cnt < STP ? '0 : cnt - STP;
      hit = cnt == '0;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      reached <= 1'b0;
    end else begin
      cnt <= nxt;
      reached <= hit;
    end
  // add-3 on every digit >= 5 before each shift
  always_comb begin
    adj = work;
    for (int d = 0; d < DIGITS; d++)
      if (adj[WIDTH+4*d +: 4] >= 4'd5) adj[WIDTH+4*d +: 4] = adj[WIDTH+4*d +: 4] + 4'd3;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      bits <= '0;
      work <= '0;
      bcd <= '0;
    end else if (nxt != cnt) begin
      work <= {{BW{1'b0}}, nxt};
      bits <= '0;
      state <= CONVERT;
    end else if (state == CONVERT) begin
      if (bits == CW'(WIDTH)) begin
        bcd <= work[BW+WIDTH-1 -: BW];
        state <= IDLE;
      end else begin
        work <= adj << 1;
        bits <= bits + 1'b1;
      end
    end
  assign bus.count = cnt;
  assign bus.count_reached = reached;
  assign bus.bcd = bcd;
  assign bus.bcd_valid = state == IDLE;
endmodule
